// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch, decode, memory, ALU and branch steps on a shared datapath.
// Optional macro MULTICYCLE_BEQ_EN enables the BEQ state; without it opcode 1100011 decodes as illegal.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_source,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // R-type ALU decode; 3'b111 marks an unsupported func3/func7 combination.
  function automatic logic [2:0] r_alu_ctrl(input logic [2:0] f3, input logic [6:0] f7);
    logic [2:0] ctl;
    ctl = 3'b111;
    case (f3)
      3'b000: begin
        if (f7 == 7'b0000000) begin
          ctl = 3'b000;
        end else if (f7 == 7'b0100000) begin
          ctl = 3'b001;
        end else begin
          ctl = 3'b111;
        end
      end
      3'b111:  ctl = (f7 == 7'b0000000) ? 3'b010 : 3'b111;
      3'b110:  ctl = (f7 == 7'b0000000) ? 3'b011 : 3'b111;
      3'b010:  ctl = (f7 == 7'b0000000) ? 3'b101 : 3'b111;
      default: ctl = 3'b111;
    endcase
    return ctl;
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic [2:0] r_ctl_s;
  logic       r_supported_s;
  logic       decode_legal_s;
  logic       mem_req_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_write_s;
  logic       reg_write_s;
  logic       illegal_s;

  assign r_ctl_s       = r_alu_ctrl(func3, func7);
  assign r_supported_s = (r_ctl_s != 3'b111);

`ifdef MULTICYCLE_BEQ_EN
  assign decode_legal_s = (op == OP_LW) || (op == OP_SW) || ((op == OP_R) && r_supported_s) ||
                          (op == OP_BEQ);
`else
  assign decode_legal_s = (op == OP_LW) || (op == OP_SW) || ((op == OP_R) && r_supported_s);
  logic unused_alu_zero_s;
  assign unused_alu_zero_s = alu_zero;
`endif

  // State register with asynchronous reset to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH:    next_state_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if ((op == OP_LW) || (op == OP_SW)) begin
          next_state_s = S_MEMADR;
        end else if ((op == OP_R) && r_supported_s) begin
          next_state_s = S_EXECUTER;
`ifdef MULTICYCLE_BEQ_EN
        end else if (op == OP_BEQ) begin
          next_state_s = S_BEQ;
`endif
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEMADR:   next_state_s = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state_s = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: next_state_s = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: next_state_s = S_ALUWB;
      S_ALUWB:    next_state_s = S_FETCH;
`ifdef MULTICYCLE_BEQ_EN
      S_BEQ:      next_state_s = S_FETCH;
`endif
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Per-state Moore outputs (FETCH and BEQ strobes also follow mem_ready / alu_zero).
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    adr_src     = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (state_r)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal_s = ~decode_legal_s;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        adr_src     = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a   = 2'b10;
        alu_control = r_ctl_s;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
      end
`ifdef MULTICYCLE_BEQ_EN
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write_s  = alu_zero;
      end
`endif
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    if (op == OP_SW) begin
      imm_source = 2'b01;
    end else if (op == OP_BEQ) begin
      imm_source = 2'b10;
    end else begin
      imm_source = 2'b00;
    end
  end

  // Side-effecting strobes are killed immediately while reset is high.
  assign mem_req       = mem_req_s   & ~reset;
  assign mem_write     = mem_write_s & ~reset;
  assign ir_write      = ir_write_s  & ~reset;
  assign pc_write      = pc_write_s  & ~reset;
  assign reg_write     = reg_write_s & ~reset;
  assign illegal_instr = illegal_s   & ~reset;
  assign state         = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, reset corner cases and a randomized instruction stream.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] func3 = 3'd0;
  logic [6:0] func7 = 7'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_source;
  logic [2:0] alu_control;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_BEQ_EN
  localparam bit BEQ_EN = 1'b1;
`else
  localparam bit BEQ_EN = 1'b0;
`endif

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ILL = 4;

  multicycle_control dut (
    .clk(clk), .reset(reset), .op(op), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_source(imm_source), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zero;
    logic [31:0] low_mask;
    int          exp_cycles;
    logic        exp_ill;
    logic [2:0]  exp_alu;
  } vec_t;

  function automatic logic [21:0] pack_dut();
    return {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            result_src, alu_src_a, alu_src_b, alu_control, imm_source, illegal_instr};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'b000 && f7 == 7'b0000000) return 3'b000;
    if (f3 == 3'b000 && f7 == 7'b0100000) return 3'b001;
    if (f7 != 7'b0000000) return 3'b111;
    if (f3 == 3'b111) return 3'b010;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b010) return 3'b101;
    return 3'b111;
  endfunction

  function automatic int classify(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    if (o == 7'b0000011) return C_LW;
    if (o == 7'b0100011) return C_SW;
    if (o == 7'b0110011) return (ref_alu(f3, f7) != 3'b111) ? C_R : C_ILL;
    if (o == 7'b1100011) return BEQ_EN ? C_BEQ : C_ILL;
    return C_ILL;
  endfunction

  // Expected outputs for one cycle, taken from the per-phase output table.
  function automatic logic [21:0] expect_out(input int ph, input int cls, input logic rdy,
                                             input logic zero, input logic [2:0] alu,
                                             input logic [6:0] o);
    logic [3:0] st;
    logic mreq, mw, adr, irw, pcw, rw, ill;
    logic [1:0] rs, a, b, imm;
    logic [2:0] ac;
    st   = 4'(ph);
    mreq = (ph == 0) || (ph == 3) || (ph == 5);
    mw   = (ph == 5);
    adr  = (ph == 3) || (ph == 5);
    irw  = (ph == 0) && rdy;
    pcw  = ((ph == 0) && rdy) || ((ph == 8) && zero);
    rw   = (ph == 4) || (ph == 7);
    rs   = (ph == 0) ? 2'b10 : (ph == 4) ? 2'b01 : 2'b00;
    a    = (ph == 1) ? 2'b01 : ((ph == 2) || (ph == 6) || (ph == 8)) ? 2'b10 : 2'b00;
    b    = (ph == 0) ? 2'b10 : ((ph == 1) || (ph == 2)) ? 2'b01 : 2'b00;
    ac   = (ph == 6) ? alu : (ph == 8) ? 3'b001 : 3'b000;
    imm  = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : 2'b00;
    ill  = (ph == 1) && (cls == C_ILL);
    return {st, mreq, mw, adr, irw, pcw, rw, rs, a, b, ac, imm, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one instruction from FETCH; called #1 after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic zero, input logic [31:0] low_mask, input int p_wait,
                           output int cycles, output logic ill_seen, output logic [2:0] exec_alu);
    int q[$];
    int cls;
    int ph;
    logic rdy;
    logic forced_low;
    logic [2:0] alu;
    cls = classify(o, f3, f7);
    alu = ref_alu(f3, f7);
    case (cls)
      C_LW:    q = '{0, 1, 2, 3, 4};
      C_SW:    q = '{0, 1, 2, 5};
      C_R:     q = '{0, 1, 6, 7};
      C_BEQ:   q = '{0, 1, 8};
      default: q = '{0, 1};
    endcase
    op = o; func3 = f3; func7 = f7; alu_zero = zero;
    cycles = 0; ill_seen = 1'b0; exec_alu = 3'b000;
    while (q.size() > 0 && cycles < 64) begin
      ph = q[0];
      forced_low = (cycles < 32) ? low_mask[cycles] : 1'b0;
      rdy = !forced_low && ($urandom_range(0, 99) >= p_wait);
      mem_ready = rdy;
      @(negedge clk);
      check("cycle_outputs", 32'(pack_dut()), 32'(expect_out(ph, cls, rdy, zero, alu, o)));
      if (illegal_instr) ill_seen = 1'b1;
      if (state == 4'd6) exec_alu = alu_control;
      if (!(((ph == 0) || (ph == 3) || (ph == 5)) && !rdy)) void'(q.pop_front());
      cycles++;
      @(posedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL instr_timeout actual=%0d cycles required=completion", cycles);
    end
  endtask

  vec_t vecs[$];
  int   cyc;
  logic ill;
  logic [2:0] xalu;

  initial begin
    vecs.push_back(vec_t'{7'b0000011, 3'b010, 7'b0000000, 1'b0, 32'h0,  5, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0100011, 3'b010, 7'b0000000, 1'b0, 32'h0,  4, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0100011, 3'b010, 7'b0000000, 1'b0, 32'h38, 7, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0000011, 3'b010, 7'b0000000, 1'b0, 32'h31, 8, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0110011, 3'b000, 7'b0000000, 1'b0, 32'h0,  4, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0110011, 3'b000, 7'b0100000, 1'b0, 32'h0,  4, 1'b0, 3'b001});
    vecs.push_back(vec_t'{7'b0110011, 3'b111, 7'b0000000, 1'b0, 32'h0,  4, 1'b0, 3'b010});
    vecs.push_back(vec_t'{7'b0110011, 3'b110, 7'b0000000, 1'b0, 32'h0,  4, 1'b0, 3'b011});
    vecs.push_back(vec_t'{7'b0110011, 3'b010, 7'b0000000, 1'b0, 32'h0,  4, 1'b0, 3'b101});
    vecs.push_back(vec_t'{7'b0110011, 3'b001, 7'b0000000, 1'b0, 32'h0,  2, 1'b1, 3'b000});
    vecs.push_back(vec_t'{7'b0110011, 3'b111, 7'b0100000, 1'b0, 32'h0,  2, 1'b1, 3'b000});
    vecs.push_back(vec_t'{7'b0110011, 3'b000, 7'b0000000, 1'b0, 32'h3,  6, 1'b0, 3'b000});
    vecs.push_back(vec_t'{7'b0010011, 3'b000, 7'b0000000, 1'b0, 32'h0,  2, 1'b1, 3'b000});
    vecs.push_back(vec_t'{7'b1100011, 3'b000, 7'b0000000, 1'b1, 32'h0,  BEQ_EN ? 3 : 2, !BEQ_EN, 3'b000});
    vecs.push_back(vec_t'{7'b1100011, 3'b000, 7'b0000000, 1'b0, 32'h0,  BEQ_EN ? 3 : 2, !BEQ_EN, 3'b000});

    // Reset held: state FETCH, strobes forced low even with mem_ready high.
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(pack_dut()),
          32'({4'd0, 6'b000000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 1'b0}));
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zero, vecs[i].low_mask, 0, cyc, ill, xalu);
      check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check($sformatf("vec%0d_illegal", i), 32'(ill), 32'(vecs[i].exp_ill));
      check($sformatf("vec%0d_alu", i), 32'(xalu), 32'(vecs[i].exp_alu));
    end

    // Reset in the middle of a stalled store.
    op = 7'b0100011; func3 = 3'b010; func7 = 7'd0; mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    check("store_stalled", 32'({state, mem_write, mem_req}), 32'({4'd5, 1'b1, 1'b1}));
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check("reset_mid_store", 32'({state, mem_write, mem_req}), 32'({4'd0, 1'b0, 1'b0}));
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(7'b0000011, 3'b010, 7'd0, 1'b0, 32'h0, 0, cyc, ill, xalu);
    check("lw_after_reset_cycles", 32'(cyc), 32'd5);

    // Randomized instruction stream with random memory stalls.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] ro;
      logic [2:0] rf3;
      logic [6:0] rf7;
      case ($urandom_range(0, 5))
        0:       ro = 7'b0000011;
        1:       ro = 7'b0100011;
        2, 3:    ro = 7'b0110011;
        4:       ro = 7'b1100011;
        default: ro = 7'($urandom);
      endcase
      rf3 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) rf7 = 7'($urandom);
      else rf7 = ($urandom_range(0, 1) == 0) ? 7'b0000000 : 7'b0100000;
      run_instr(ro, rf3, rf7, 1'($urandom), 32'h0, 30, cyc, ill, xalu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle control unit for the RV32I core: a Moore FSM that sequences the shared datapath (one ALU, one unified instruction/data memory port, register file) across several cycles per instruction. It replaces the single-cycle decoder's combinational output set with per-state strobes and adds a memory ready handshake so fetch and data accesses can stall. It sits between the instruction register / memory interface and the datapath muxes and enables.

## Interface
Parameters: none.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  7  instruction[6:0], valid from IR (stable DECODE onward).
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- alu_zero  in  1  ALU zero flag, combinational from current ALU operation.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested this cycle.
- mem_write  out  1  access is a store.
- adr_src  out  1  0 = PC, 1 = ALUOut drives memory address.
- ir_write  out  1  load IR and old-PC register.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  write register file rd.
- result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result (direct).
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1 data.
- alu_src_b  out  2  00 rs2 data, 01 immediate, 10 constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 unsupported.
- imm_source  out  2  00 I-type, 01 S-type, 10 B-type.
- illegal_instr  out  1  one-cycle pulse in DECODE for unsupported opcode/function.
- state  out  4  current state encoding (debug).

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, BEQ 8.
- Outputs not listed per state are 0; alu_src/result_src default 00.
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; ir_write=pc_write=mem_ready. Stays until mem_ready, then DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next: op 0000011/0100011 -> MEMADR; 0110011 with supported funct -> EXECUTER; 1100011 -> BEQ; else illegal_instr=1, -> FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, add. LW -> MEMREAD, SW -> MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; holds until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; holds until mem_ready, then FETCH. mem_write held constant while waiting.
- EXECUTER: alu_src_a=10, alu_src_b=00, funct-decoded ALU op -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=alu_zero -> FETCH.
- R-type decode (op 0110011): func3 000 & func7 0000000 add; 000 & 0100000 sub; 111 and; 110 or; 010 slt (func7 0000000 required for last three); anything else illegal.
- imm_source from op in every state: 0100011 -> 01, 1100011 -> 10, else 00.

## Timing
- Cycles per instruction with mem_ready tied 1: LW 5, SW 4, R-type 4, BEQ 3, illegal 2. Each low mem_ready cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Reset (asynchronous assert, synchronous-to-clk deassert by system): state=FETCH; while reset high, ir_write, pc_write, reg_write, mem_write, mem_req, illegal_instr forced 0; other outputs show FETCH values. Reset mid-store drops mem_write the same instant.
- First FETCH request issued in the first clk cycle after reset deasserts.
- mem_ready outside request states is ignored.

## Configuration
- MULTICYCLE_BEQ_EN: defined -> BEQ state and opcode 1100011 supported as above. Undefined -> no BEQ state; 1100011 treated as illegal (pulse, return to FETCH); imm_source still returns 10 for that opcode.

## Test plan
- Reset asserted mid-MEMWRITE with mem_ready=0 -> state=0, mem_write=0 immediately; after release, FETCH with mem_req=1 next cycle.
- LW (op 0000011), mem_ready=1 -> states 0,1,2,3,4; reg_write=1 only in state 4 with result_src=01; 5 cycles.
- SW, mem_ready low 3 cycles in MEMWRITE -> mem_write/mem_req held 4 cycles, then FETCH; total 7 cycles, reg_write never 1.
- R-type func3 000 func7 0100000 -> EXECUTER alu_control=001, ALUWB reg_write=1; func3 111 -> 010; func3 001 -> illegal_instr pulse, back to FETCH.
- BEQ with macro, alu_zero=1 -> pc_write=1 in state 8; alu_zero=0 -> pc_write=0; 3 cycles each.
- Fetch with mem_ready=0 for 2 cycles -> ir_write/pc_write stay 0, state 0, then 1-cycle strobe when ready.
